cu_seq: RTL
===========

# cu_seq

Parametrised multi-cycle control sequencer, the successor of the single-cycle `cu`, sitting between the instruction memory port and the datapath (register file, ALU, branch unit, LSU, PC). It does four things:
- accepts one RV32I instruction per handshake;
- decodes it into registered datapath controls;
- steps it through DECODE/EXEC/MEM/WB states with a bounded load-wait;
- traps on illegal encodings or memory timeout.

It supports full (32-register) and RV32E (16-register) configurations.

## Interface
- REG_ADR_W, 5: register-address width; 5 = 32 regs, 4 = RV32E (indices ≥16 illegal); ports drive 5 bits, upper bit 0 when 4.
- MEM_TIMEOUT, 16: max cycles waiting for READ_READY in MEM before a trap; legal range 1..255.
- CLK in 1: single clock, rising edge.
- RST_N in 1: asynchronous, active-low reset.
- MEM_INST in 32: instruction word, valid while INST_ENB=1.
- INST_ENB in 1: instruction offered.
- READ_READY in 1: LSU load data valid.
- TRAP_CLR in 1: leave TRAP state.
- INST_ACK out 1: one-cycle pulse, instruction accepted.
- RS1_ADR, RS2_ADR, REG_ADR out 5: source/destination register indices.
- ALU_OPT out 4: {funct7[5], funct3} for R-type and shift-imm; {0, funct3} for other OP-IMM; 0000 (add) for loads, stores, AUIPC, LUI, JAL, JALR.
- BR_OPT out 3: funct3 for branches, else 0.
- LSU_OPT out 3: funct3 for loads/stores, else 0.
- IMM_TYPE out 3: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- RS1_MUX_SELECT out 3: 0 reg, 1 PC, 2 zero.
- RS2_MUX_SELECT out 3: 0 reg, 1 imm.
- REG_MUX_SELECT out 3: 0 ALU, 1 load data, 2 PC+4.
- PC_MUX_SELECT out 3: 0 PC+4, 1 branch target (taken-ness from branch unit), 2 ALU result (JALR).
- WRITE_ENB out 1: register-file write strobe.
- MEM_WRITE_ENB out 1: store strobe.
- PC_ENB out 1: PC update strobe.
- TRAP out 1: sequencer halted.
- TRAP_CAUSE out 2: 0 none, 1 illegal instruction, 2 load timeout.

## Operation
- States: IDLE, DECODE, EXEC, MEM, WB, TRAP.
- IDLE:
  - INST_ENB=1 at an edge latches MEM_INST, registers INST_ACK=1 for one cycle, and moves to DECODE.
  - INST_ENB is ignored in every other state.
- DECODE: register all control fields from the latched word. Any of the following → TRAP, cause 1:
  - unknown opcode;
  - R-type funct7 ∉ {0x00, 0x20};
  - funct7=0x20 with funct3 ∉ {0, 5};
  - shift-imm funct7 illegal;
  - load funct3 ∈ {3, 6, 7};
  - store funct3 > 2;
  - branch funct3 ∈ {2, 3};
  - a used register index ≥ 2^REG_ADR_W.
- FENCE and SYSTEM opcodes are treated as illegal.
- EXEC:
  - stores: MEM_WRITE_ENB=1 this cycle only, then WB.
  - loads: go to MEM, clear the wait counter.
  - all others: go to WB.
- MEM:
  - READ_READY=1 → WB.
  - Otherwise the counter increments; if READ_READY is still 0 after MEM_TIMEOUT cycles in MEM → TRAP, cause 2.
  - READ_READY and timeout in the same cycle: READ_READY wins.
- WB:
  - WRITE_ENB=1 when the instruction writes rd and REG_ADR≠0; branches and stores never write.
  - PC_ENB=1.
  - Go to IDLE.
- TRAP:
  - TRAP=1, all strobes 0.
  - TRAP_CLR=1 → IDLE, TRAP_CAUSE cleared.
- Control fields stay stable from DECODE until the next acceptance; strobes are registered and glitch-free.

## Timing
- Reset (RST_N=0, asynchronous, any state including mid-MEM):
  - state IDLE;
  - all outputs 0; TRAP_CAUSE 0;
  - counter 0 and latched instruction 0.
- Release of reset is synchronous to CLK.
- Acceptance at edge k: INST_ACK high in cycle k..k+1, DECODE k+1, EXEC k+2.
- Non-load: WB k+3, WRITE_ENB/PC_ENB high for exactly one cycle; next acceptance possible at edge k+4. Throughput is 4 cycles per instruction.
- Store: MEM_WRITE_ENB high in EXEC (cycle k+2..k+3).
- Load with READ_READY first seen in MEM cycle n (n=1 is the first MEM cycle): WB in cycle k+3+n; MEM occupies cycles k+3..k+2+n.
- Load with no READ_READY: TRAP entered after MEM_TIMEOUT MEM cycles; no WRITE_ENB, no PC_ENB.
- Illegal instruction: TRAP entered the cycle after DECODE; no strobe is ever asserted for it.

## Test plan
- Arithmetic: reset, then 0x06308093 (addi x1,x1,0x63) → INST_ACK pulse; ALU_OPT 0000, IMM_TYPE 1, RS2_MUX 1, REG_ADR 1; WRITE_ENB and PC_ENB single pulse 3 cycles after acceptance. Then 0x40118233 (sub x4,x3,x1) → ALU_OPT 1000, RS1 3, RS2 1, RS2_MUX 0.
- Store: 0x00302023 (sw x3,0(x0)) → LSU_OPT 010, IMM_TYPE 2, MEM_WRITE_ENB one pulse in EXEC, WRITE_ENB never high, PC_ENB one pulse.
- Load wait: 0x00002883 (lw x17) with READ_READY raised 3 cycles into MEM → REG_MUX 1, REG_ADR 17, WRITE_ENB one pulse at cycle k+6. Second run with READ_READY held 0, MEM_TIMEOUT=4 → TRAP=1, TRAP_CAUSE 2, no WRITE_ENB.
- Control flow:
  - 0x00108663 (beq x1,x1,12) → IMM_TYPE 3, BR_OPT 000, PC_MUX 1, WRITE_ENB 0.
  - 0x00c00aef (jal x21,12) → IMM_TYPE 5, PC_MUX 1, REG_MUX 2, REG_ADR 21, RS1_MUX 1.
- Illegal and RV32E: 0x00000000 → TRAP cause 1; TRAP_CLR → IDLE. With REG_ADR_W=4, 0x00c00aef → TRAP cause 1 (x21 out of range), while 0x00110113 → normal completion.
- Reset mid-operation: RST_N pulled low during MEM and during WB → all outputs 0 immediately (no clock edge required). The next instruction after release executes normally.

Source files
------------

// File: rtl/cu_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cu_seq_if : instruction-fetch handshake and datapath control bundle        |
// | Rev 1.0                                                                    |
// +-----------------------------------------------------------------------------+
interface cu_seq_if;
  logic [31:0] mem_inst;
  logic        inst_enb;
  logic        read_ready;
  logic        trap_clr;
  logic        inst_ack;
  logic [4:0]  rs1_adr;
  logic [4:0]  rs2_adr;
  logic [4:0]  reg_adr;
  logic [3:0]  alu_opt;
  logic [2:0]  br_opt;
  logic [2:0]  lsu_opt;
  logic [2:0]  imm_type;
  logic [2:0]  rs1_mux_select;
  logic [2:0]  rs2_mux_select;
  logic [2:0]  reg_mux_select;
  logic [2:0]  pc_mux_select;
  logic        write_enb;
  logic        mem_write_enb;
  logic        pc_enb;
  logic        trap;
  logic [1:0]  trap_cause;

  // The sequencer side drives the controls; the environment drives the fetch word.
  modport master (
    input  mem_inst, inst_enb, read_ready, trap_clr,
    output inst_ack, rs1_adr, rs2_adr, reg_adr, alu_opt, br_opt, lsu_opt, imm_type,
           rs1_mux_select, rs2_mux_select, reg_mux_select, pc_mux_select,
           write_enb, mem_write_enb, pc_enb, trap, trap_cause
  );

  modport slave (
    output mem_inst, inst_enb, read_ready, trap_clr,
    input  inst_ack, rs1_adr, rs2_adr, reg_adr, alu_opt, br_opt, lsu_opt, imm_type,
           rs1_mux_select, rs2_mux_select, reg_mux_select, pc_mux_select,
           write_enb, mem_write_enb, pc_enb, trap, trap_cause
  );
endinterface
`default_nettype wire

// File: rtl/cu_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cu_seq : multi-cycle RV32I/RV32E control sequencer with load-wait and trap |
// | Rev 1.0                                                                    |
// +-----------------------------------------------------------------------------+
module cu_seq #(
  parameter int REG_ADR_W   = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  cu_seq_if.master bus
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  localparam logic [2:0] c_IMM_NONE = 3'd0;
  localparam logic [2:0] c_IMM_I    = 3'd1;
  localparam logic [2:0] c_IMM_S    = 3'd2;
  localparam logic [2:0] c_IMM_B    = 3'd3;
  localparam logic [2:0] c_IMM_U    = 3'd4;
  localparam logic [2:0] c_IMM_J    = 3'd5;

  localparam logic [5:0] c_REG_LIMIT    = 6'(1 << REG_ADR_W);
  localparam logic [4:0] c_REG_MASK     = 5'((1 << REG_ADR_W) - 1);
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_inst;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic        r_is_load, r_is_store, r_wr_rd;
  logic        r_ack, r_we, r_mwe, r_pce, r_trap;
  logic [1:0]  r_cause;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [3:0]  r_alu;
  logic [2:0]  r_br, r_lsu, r_imm, r_rs1_mux, r_rs2_mux, r_reg_mux, r_pc_mux;

  logic        w_ack_nx, w_we_nx, w_mwe_nx, w_pce_nx, w_trap_nx;
  logic [1:0]  w_cause_nx;
  logic        w_latch, w_decode;

  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd_f, w_rs1_f, w_rs2_f;
  logic [3:0]  w_alu;
  logic [2:0]  w_br, w_lsu, w_imm, w_rs1_mux, w_rs2_mux, w_reg_mux, w_pc_mux;
  logic        w_use_rs1, w_use_rs2, w_use_rd, w_is_load, w_is_store, w_bad_enc, w_illegal;

  assign w_opcode = r_inst[6:0];
  assign w_rd_f   = r_inst[11:7];
  assign w_f3     = r_inst[14:12];
  assign w_rs1_f  = r_inst[19:15];
  assign w_rs2_f  = r_inst[24:20];
  assign w_f7     = r_inst[31:25];

  function automatic logic bad_idx(input logic [4:0] idx);
    return {1'b0, idx} >= c_REG_LIMIT;
  endfunction

  always_comb begin
    w_alu      = 4'd0;
    w_br       = 3'd0;
    w_lsu      = 3'd0;
    w_imm      = c_IMM_NONE;
    w_rs1_mux  = 3'd0;
    w_rs2_mux  = 3'd0;
    w_reg_mux  = 3'd0;
    w_pc_mux   = 3'd0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_use_rd   = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_bad_enc  = 1'b0;
    case (w_opcode)
      c_OP_LUI: begin
        w_imm = c_IMM_U; w_rs1_mux = 3'd2; w_rs2_mux = 3'd1; w_use_rd = 1'b1;
      end
      c_OP_AUIPC: begin
        w_imm = c_IMM_U; w_rs1_mux = 3'd1; w_rs2_mux = 3'd1; w_use_rd = 1'b1;
      end
      c_OP_JAL: begin
        w_imm = c_IMM_J; w_rs1_mux = 3'd1; w_rs2_mux = 3'd1;
        w_reg_mux = 3'd2; w_pc_mux = 3'd1; w_use_rd = 1'b1;
      end
      c_OP_JALR: begin
        w_imm = c_IMM_I; w_rs2_mux = 3'd1; w_reg_mux = 3'd2; w_pc_mux = 3'd2;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1;
      end
      c_OP_BRANCH: begin
        w_imm = c_IMM_B; w_br = w_f3; w_pc_mux = 3'd1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_bad_enc = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      c_OP_LOAD: begin
        w_imm = c_IMM_I; w_rs2_mux = 3'd1; w_reg_mux = 3'd1; w_lsu = w_f3;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_is_load = 1'b1;
        w_bad_enc = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      c_OP_STORE: begin
        w_imm = c_IMM_S; w_rs2_mux = 3'd1; w_lsu = w_f3;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_store = 1'b1;
        w_bad_enc = (w_f3 > 3'd2);
      end
      c_OP_IMM: begin
        w_imm = c_IMM_I; w_rs2_mux = 3'd1; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
        // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 5.
        if (w_f3 == 3'd1) begin
          w_alu     = {w_f7[5], w_f3};
          w_bad_enc = (w_f7 != 7'h00);
        end else if (w_f3 == 3'd5) begin
          w_alu     = {w_f7[5], w_f3};
          w_bad_enc = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        end else begin
          w_alu = {1'b0, w_f3};
        end
      end
      c_OP_REG: begin
        w_alu = {w_f7[5], w_f3};
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
        w_bad_enc = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                    ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5));
      end
      default: w_bad_enc = 1'b1;
    endcase
  end

  assign w_illegal = w_bad_enc
                   | (w_use_rs1 & bad_idx(w_rs1_f))
                   | (w_use_rs2 & bad_idx(w_rs2_f))
                   | (w_use_rd  & bad_idx(w_rd_f));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ack_nx   = 1'b0;
    w_we_nx    = 1'b0;
    w_mwe_nx   = 1'b0;
    w_pce_nx   = 1'b0;
    w_trap_nx  = r_trap;
    w_cause_nx = r_cause;
    w_latch    = 1'b0;
    w_decode   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.inst_enb) begin
          w_state_nx = S_DECODE;
          w_ack_nx   = 1'b1;
          w_latch    = 1'b1;
        end
      end
      S_DECODE: begin
        w_decode = 1'b1;
        if (w_illegal) begin
          w_state_nx = S_TRAP;
          w_trap_nx  = 1'b1;
          w_cause_nx = 2'd1;
        end else begin
          w_state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_is_load) begin
          w_state_nx = S_MEM;
          w_cnt_nx   = 8'd0;
        end else begin
          w_state_nx = S_WB;
          w_mwe_nx   = r_is_store;
        end
      end
      S_MEM: begin
        // Data arriving on the last permitted cycle still completes the load.
        if (bus.read_ready) begin
          w_state_nx = S_WB;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_nx = S_TRAP;
          w_trap_nx  = 1'b1;
          w_cause_nx = 2'd2;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_WB: begin
        w_we_nx    = r_wr_rd;
        w_pce_nx   = 1'b1;
        w_state_nx = S_IDLE;
      end
      S_TRAP: begin
        if (bus.trap_clr) begin
          w_state_nx = S_IDLE;
          w_trap_nx  = 1'b0;
          w_cause_nx = 2'd0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst     <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_we       <= 1'b0;
      r_mwe      <= 1'b0;
      r_pce      <= 1'b0;
      r_trap     <= 1'b0;
      r_cause    <= 2'd0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_wr_rd    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_alu      <= '0;
      r_br       <= '0;
      r_lsu      <= '0;
      r_imm      <= '0;
      r_rs1_mux  <= '0;
      r_rs2_mux  <= '0;
      r_reg_mux  <= '0;
      r_pc_mux   <= '0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_ack   <= w_ack_nx;
      r_we    <= w_we_nx;
      r_mwe   <= w_mwe_nx;
      r_pce   <= w_pce_nx;
      r_trap  <= w_trap_nx;
      r_cause <= w_cause_nx;
      if (w_latch) r_inst <= bus.mem_inst;
      if (w_decode) begin
        r_is_load  <= w_is_load;
        r_is_store <= w_is_store;
        r_wr_rd    <= w_use_rd && (w_rd_f != 5'd0);
        r_rs1      <= w_use_rs1 ? (w_rs1_f & c_REG_MASK) : 5'd0;
        r_rs2      <= w_use_rs2 ? (w_rs2_f & c_REG_MASK) : 5'd0;
        r_rd       <= w_use_rd  ? (w_rd_f  & c_REG_MASK) : 5'd0;
        r_alu      <= w_alu;
        r_br       <= w_br;
        r_lsu      <= w_lsu;
        r_imm      <= w_imm;
        r_rs1_mux  <= w_rs1_mux;
        r_rs2_mux  <= w_rs2_mux;
        r_reg_mux  <= w_reg_mux;
        r_pc_mux   <= w_pc_mux;
      end
    end
  end

  assign bus.inst_ack       = r_ack;
  assign bus.rs1_adr        = r_rs1;
  assign bus.rs2_adr        = r_rs2;
  assign bus.reg_adr        = r_rd;
  assign bus.alu_opt        = r_alu;
  assign bus.br_opt         = r_br;
  assign bus.lsu_opt        = r_lsu;
  assign bus.imm_type       = r_imm;
  assign bus.rs1_mux_select = r_rs1_mux;
  assign bus.rs2_mux_select = r_rs2_mux;
  assign bus.reg_mux_select = r_reg_mux;
  assign bus.pc_mux_select  = r_pc_mux;
  assign bus.write_enb      = r_we;
  assign bus.mem_write_enb  = r_mwe;
  assign bus.pc_enb         = r_pce;
  assign bus.trap           = r_trap;
  assign bus.trap_cause     = r_cause;

endmodule
`default_nettype wire
